// File: rtl/updown_cnt_nb.sv
// Up/down counter with a programmable terminal value, wrap or saturate at the range ends,
// and a parallel load. Also provides limit flags and a thermometer bar-graph output.
module updown_cnt_nb #(
    parameter int N    = 4,
    parameter int MAXV = 15,
    parameter int LEDS = 15
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            ce,
    input  logic            up,
    input  logic            ld,
    input  logic [N-1:0]    din,
    input  logic            sat,
    output logic [N-1:0]    cnt,
    output logic            tc,
    output logic            sat_hit,
    output logic            at_max,
    output logic            at_min,
    output logic [LEDS-1:0] bar
);

    localparam logic [N-1:0] MAX_C = N'(MAXV);

    logic [N-1:0] cnt_q, cnt_d;
    logic         tc_q, tc_d;
    logic         sat_hit_q, sat_hit_d;

    always_comb begin
        cnt_d     = cnt_q;
        tc_d      = 1'b0;
        sat_hit_d = sat_hit_q;
        if (ld) begin
            cnt_d     = (din > MAX_C) ? MAX_C : din;
            sat_hit_d = 1'b0;
        end else if (ce) begin
            if (up) begin
                if (cnt_q < MAX_C) begin
                    cnt_d = cnt_q + N'(1);
                end else if (sat) begin
                    sat_hit_d = 1'b1;
                end else begin
                    cnt_d = '0;
                    tc_d  = 1'b1;
                end
            end else begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - N'(1);
                end else if (sat) begin
                    sat_hit_d = 1'b1;
                end else begin
                    cnt_d = MAX_C;
                    tc_d  = 1'b1;
                end
            end
        end
    end

    // clr overrides every other request on the same edge
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q     <= '0;
            tc_q      <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tc_q      <= tc_d;
            sat_hit_q <= sat_hit_d;
        end
    end

    assign cnt     = cnt_q;
    assign tc      = tc_q;
    assign sat_hit = sat_hit_q;
    assign at_max  = (cnt_q == MAX_C);
    assign at_min  = (cnt_q == '0);

    // cnt never exceeds MAXV, so segments at or above MAXV stay dark on their own
    for (genvar g = 0; g < LEDS; g++) begin : g_bar
        assign bar[g] = (int'(cnt_q) > g);
    end

endmodule

// File: tb/tb_updown_cnt_nb.sv
// Bench for updown_cnt_nb: two instances (terminal values 15 and 9) share one stimulus stream;
// an arithmetic model is compared every cycle, plus literal expectations for key scenarios.
module tb_updown_cnt_nb;

    logic        clk;
    logic        clr, ce, up, ld, sat;
    logic [3:0]  din;

    logic [3:0]  a_cnt, b_cnt;
    logic        a_tc, b_tc, a_hit, b_hit, a_max, b_max, a_min, b_min;
    logic [14:0] a_bar, b_bar;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    int mx [2] = '{15, 9};
    int m_cnt [2];
    int m_tc [2];
    int m_hit [2];

    updown_cnt_nb #(.N(4), .MAXV(15), .LEDS(15)) u_a (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .ld(ld), .din(din), .sat(sat),
        .cnt(a_cnt), .tc(a_tc), .sat_hit(a_hit), .at_max(a_max), .at_min(a_min), .bar(a_bar)
    );

    updown_cnt_nb #(.N(4), .MAXV(9), .LEDS(15)) u_b (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .ld(ld), .din(din), .sat(sat),
        .cnt(b_cnt), .tc(b_tc), .sat_hit(b_hit), .at_max(b_max), .at_min(b_min), .bar(b_bar)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: a step moves by +/-1 within 0..maxv; leaving that range either wraps (mod maxv+1) or is blocked.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int c, t, h, nxt;
            c = m_cnt[k];
            t = 0;
            h = m_hit[k];
            if (clr) begin
                c = 0;
                h = 0;
            end else if (ld) begin
                c = (int'(din) > mx[k]) ? mx[k] : int'(din);
                h = 0;
            end else if (ce) begin
                nxt = c + (up ? 1 : -1);
                if (nxt < 0 || nxt > mx[k]) begin
                    if (sat) h = 1;
                    else begin
                        c = (nxt + mx[k] + 1) % (mx[k] + 1);
                        t = 1;
                    end
                end else begin
                    c = nxt;
                end
            end
            m_cnt[k] <= c;
            m_tc[k]  <= t;
            m_hit[k] <= h;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_cnt", a_cnt, m_cnt[0]);
            chk("a_tc", a_tc, m_tc[0]);
            chk("a_hit", a_hit, m_hit[0]);
            chk("a_max", a_max, m_cnt[0] == mx[0]);
            chk("a_min", a_min, m_cnt[0] == 0);
            chk("a_bar", a_bar, ((1 << m_cnt[0]) - 1) & 32'h7FFF);
            chk("b_cnt", b_cnt, m_cnt[1]);
            chk("b_tc", b_tc, m_tc[1]);
            chk("b_hit", b_hit, m_hit[1]);
            chk("b_max", b_max, m_cnt[1] == mx[1]);
            chk("b_min", b_min, m_cnt[1] == 0);
            chk("b_bar", b_bar, ((1 << m_cnt[1]) - 1) & 32'h7FFF);
        end
    end

    initial begin
        clr = 1; ce = 0; up = 0; ld = 0; sat = 0; din = 0;
        cyc();
        chk_en = 1;
        clr = 0;
        chk("rst_cnt", a_cnt, 0);
        chk("rst_min", a_min, 1);
        chk("rst_max", a_max, 0);
        chk("rst_bar", a_bar, 0);
        chk("rst_hit", b_hit, 0);

        // count up through the wrap on MAXV=15
        up = 1; sat = 0; ce = 1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk("inc_cnt", a_cnt, i % 16);
            chk("inc_tc", a_tc, (i == 16) ? 1 : 0);
            if (i == 15) chk("inc_bar15", a_bar, 15'h7FFF);
        end
        ce = 0;
        cyc();
        chk("inc_tc_off", a_tc, 0);

        // down-wrap from reset on MAXV=9
        clr = 1; cyc(); clr = 0;
        up = 0; ce = 1; cyc(); ce = 0;
        chk("dn_cnt", b_cnt, 9);
        chk("dn_tc", b_tc, 1);
        chk("dn_max", b_max, 1);
        chk("dn_bar", b_bar, 15'h01FF);
        cyc();
        chk("dn_tc_off", b_tc, 0);

        // saturation at the top, then count away
        clr = 1; cyc(); clr = 0;
        ld = 1; din = 15; cyc(); ld = 0;
        sat = 1; up = 1; ce = 1;
        cyc();
        chk("sat_cnt", a_cnt, 15);
        chk("sat_tc", a_tc, 0);
        chk("sat_hit", a_hit, 1);
        cyc(); cyc();
        chk("sat_cnt3", a_cnt, 15);
        up = 0;
        cyc(); cyc();
        chk("sat_down", a_cnt, 13);
        chk("sat_sticky", a_hit, 1);
        chk("sat_hit_b", b_hit, 1);

        // load beats ce and clamps
        ld = 1; din = 12; ce = 1; cyc(); ld = 0; ce = 0;
        chk("ld_clamp", b_cnt, 9);
        chk("ld_tc", b_tc, 0);
        chk("ld_hit", b_hit, 0);
        chk("ld_a", a_cnt, 12);

        // clr coincident with a wrapping tick
        ld = 1; din = 15; cyc(); ld = 0;
        up = 1; sat = 0; clr = 1; ce = 1; cyc(); clr = 0; ce = 0;
        chk("clr_cnt", a_cnt, 0);
        chk("clr_tc", a_tc, 0);
        chk("clr_hit", a_hit, 0);

        // idle with toggling up/sat must not change state
        ld = 1; din = 9; cyc(); ld = 0;
        sat = 1; up = 1; ce = 1; cyc(); ce = 0;
        for (int i = 0; i < 100; i++) begin
            up = ~up; sat = ~sat;
            cyc();
        end
        chk("idle_a_cnt", a_cnt, 10);
        chk("idle_b_cnt", b_cnt, 9);
        chk("idle_b_hit", b_hit, 1);
        chk("idle_a_tc", a_tc, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            ce  = $urandom_range(0, 1);
            up  = $urandom_range(0, 1);
            sat = ($urandom_range(0, 3) == 0);
            din = 4'($urandom);
            cyc();
        end
        clr = 0; ld = 0; ce = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_cnt_nb.md
UPDOWN_CNT_NB -- requirements
Module: updown_cnt_nb

Interface
REQ-001 SHALL have parameter N, default 4, meaning counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter MAXV, default 15, meaning terminal (largest) count value (legal range 1..2^N-1).
REQ-003 SHALL have parameter LEDS, default 15, meaning width of bar-graph output.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port clr  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port ce  input  1  count enable; one-cycle tick from an external divider; one step per high cycle.
REQ-007 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port ld  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port din  input  N  load value.
REQ-010 SHALL have port sat  input  1  end-of-range mode; 0 = wrap, 1 = saturate.
REQ-011 SHALL have port cnt  output  N  present count (registered).
REQ-012 SHALL have port tc  output  1  wrap pulse (registered).
REQ-013 SHALL have port sat_hit  output  1  sticky flag: a step was blocked at a range limit (registered).
REQ-014 SHALL have port at_max  output  1  cnt == MAXV (combinational from cnt).
REQ-015 SHALL have port at_min  output  1  cnt == 0 (combinational from cnt).
REQ-016 SHALL have port bar  output  LEDS  thermometer display of cnt.

Function
REQ-017 SHALL evaluate control priority per edge as clr > ld > ce; lower-priority requests in the same cycle are ignored, not queued.
REQ-018 SHALL, on ld, load cnt <= din when din <= MAXV, else cnt <= MAXV (clamp); tc <= 0; sat_hit <= 0.
REQ-019 SHALL hold cnt, with tc <= 0, on any edge with clr = ld = ce = 0.
REQ-020 SHALL, on ce with up = 1 and cnt < MAXV, set cnt <= cnt + 1, tc <= 0.
REQ-021 SHALL, on ce with up = 0 and cnt > 0, set cnt <= cnt - 1, tc <= 0.
REQ-022 SHALL, on ce with up = 1, cnt == MAXV, sat = 0, set cnt <= 0 and tc <= 1.
REQ-023 SHALL, on ce with up = 0, cnt == 0, sat = 0, set cnt <= MAXV and tc <= 1.
REQ-024 SHALL, on ce at a limit (up = 1 at MAXV or up = 0 at 0) with sat = 1, hold cnt, set tc <= 0, set sat_hit <= 1.
REQ-025 SHALL keep sat_hit high until clr or ld; counting away from the limit does not clear it.
REQ-026 SHALL hold tc high for exactly one clk cycle, coincident with the first cycle cnt shows the wrapped value; back-to-back ce ticks produce no tc unless each wraps.
REQ-027 SHALL sample up and sat only on ce edges; changing them between ticks has no effect on state.
REQ-028 SHALL drive bar[i] = 1 iff cnt > i, for i = 0..LEDS-1; bits with i >= MAXV always 0; bar derived from registered cnt with no extra latency.
REQ-029 SHALL use N-bit unsigned arithmetic; no intermediate value outside 0..MAXV is ever stored in cnt.
REQ-030 SHALL make the wrap point MAXV, not 2^N-1, in both directions when MAXV < 2^N-1.

Reset
REQ-031 SHALL, on any edge with clr = 1, set cnt = 0, tc = 0, sat_hit = 0, regardless of ld, ce, up, sat.
REQ-032 SHALL, after reset, present at_min = 1, at_max = 0 (MAXV >= 1), bar = all zeros.
REQ-033 SHALL, on clr asserted mid-count or coincident with a wrapping ce, produce no tc pulse on the following cycle.

Verification
REQ-034 SHALL pass: N=4, MAXV=15, sat=0, up=1, 16 ce ticks from reset -> cnt 1..15 then 0; tc high one cycle only at 15->0; bar = 15'h7FFF at cnt=15.
REQ-035 SHALL pass: N=4, MAXV=9, sat=0, up=0, one ce from reset -> cnt=9, tc=1 one cycle, at_max=1, bar = 15'h01FF.
REQ-036 SHALL pass: sat=1, ld din=15 (MAXV=15), up=1, 3 ce ticks -> cnt stays 15, tc=0, sat_hit=1 after first tick; up=0, 2 ticks -> cnt=13, sat_hit still 1.
REQ-037 SHALL pass: MAXV=9, ld=1 with din=12 and ce=1 same cycle -> cnt=9 (clamped), tc=0, sat_hit cleared.
REQ-038 SHALL pass: cnt=15, up=1, sat=0, clr=1 and ce=1 same cycle -> cnt=0, tc=0 next cycle, sat_hit=0.
REQ-039 SHALL pass: ce held 0 for 100 cycles while up and sat toggle every cycle -> cnt, tc, sat_hit unchanged.
